shift_right_unit: RTL and testbench
===================================

Name: shift_right_unit

Overview:
- Multi-cycle right shifter for the R-type datapath; executes SRL/SRA/SRLV/SRAV.
- Complements the existing combinational left shift used for branch offsets.
- Iterative, STEP bits per cycle, trading latency for area.
- Start/done handshake; the pipeline stall logic holds EX while busy_o is high.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).
- STEP, 1, maximum bits shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request; accepted only when state is IDLE or DONE.
- val_i  in  WIDTH  operand (rt).
- shamt_i  in  SHAMT_W  shift amount (shamt field or rs[4:0]).
- arith_i  in  1  1 = SRA (sign fill), 0 = SRL (zero fill).
- busy_o  out  1  high while in SHIFT.
- done_o  out  1  one-cycle pulse; result_o valid.
- result_o  out  WIDTH  shifted value.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset: state=IDLE, acc=0, cnt=0, fill=0, busy_o=0, done_o=0, result_o=0.
- rst wins over all other inputs, including mid-SHIFT; any operation in flight is discarded and no done_o is produced.
- States: IDLE, SHIFT, DONE.
- Start acceptance: start_i sampled high in IDLE or DONE latches acc<=val_i, cnt<=shamt_i and fill<=arith_i & val_i[WIDTH-1].
  - Next state is DONE if shamt_i==0, else SHIFT.
- start_i in SHIFT is ignored: not queued, no effect on acc or cnt.
- SHIFT, each edge:
  - k = min(STEP, cnt).
  - acc <= acc >> k, vacated MSBs filled with fill.
  - cnt <= cnt - k.
  - If cnt <= STEP, next state is DONE.
- DONE: done_o=1 for exactly one cycle. Without start_i the next state is IDLE; with start_i the new request is accepted (back-to-back, no bubble).
- Outputs:
  - busy_o = (state==SHIFT), combinational from the state register.
  - done_o = (state==DONE).
  - result_o = acc; holds its value in IDLE until the next start is accepted.
- Latency from the start edge to done_o high: 1 cycle if shamt==0, else 1+ceil(shamt/STEP) cycles. Example: STEP=1, shamt=31 gives 32 cycles.
- Width rules:
  - Shift amounts are unsigned, 0..WIDTH-1; no shift of WIDTH or more exists.
  - SRA by WIDTH-1 yields all-ones or all-zeros according to the original sign.
- arith_i and val_i are sampled only at acceptance; later changes are ignored.

Optional Feature:
- Macro: SHIFT_RIGHT_ROTATE_EN.
- Defined:
  - Adds input port rot_i (1 bit), sampled at acceptance.
  - rot_i=1 selects ROTR: vacated MSBs take the bits shifted out of the LSBs.
  - rot_i has priority over arith_i.
  - Latency is unchanged.
- Undefined: port rot_i is absent; only logical and arithmetic shifts exist.

Decomposition:
- Package shift_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - SHAMT_W and legal-STEP constants;
  - fill-mode encoding {FILL_ZERO, FILL_SIGN, FILL_ROT}.
- Sub-module shr_step: combinational single-step shifter.
  - Inputs: acc, k (0..STEP), fill mode.
  - Output: the shifted word.
  - Instantiated once in the FSM datapath.

Test Plan:
- SRL, STEP=1: val=0x80000000, shamt=4, arith=0, start at cycle 0. Required: busy_o high cycles 1-4, done_o at cycle 5, result_o=0x08000000.
- SRA, STEP=1: val=0x80000000, shamt=4, arith=1. Required: result_o=0xF8000000. Then val=0x80000000, shamt=31, arith=1: result_o=0xFFFFFFFF, done_o 32 cycles after start.
- shamt=0: val=0x12345678. Required: done_o one cycle after start, result_o=0x12345678, busy_o never high. STEP=4, shamt=9: done_o after 4 cycles.
- Busy collision, STEP=1: start_i with val=0xFFFF0000, shamt=8, SRL; pulse start_i again at cycle 3 with val=0x1. Required: second start ignored, result_o=0x00FFFF00. Start asserted in the DONE cycle is accepted, with no idle cycle between operations.
- rst at cycle 2 of a shamt=10 operation. Required: next cycle state=IDLE, busy_o=0, result_o=0; no done_o pulse follows.
- SHIFT_RIGHT_ROTATE_EN defined, rot_i=1: val=0x00000001, shamt=1 gives result_o=0x80000000; val=0x0000000F, shamt=4 gives 0xF0000000.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle right shifter.
//   state_e      : controller states IDLE / SHIFT / DONE
//   fill_mode_e  : what enters the vacated MSBs (zeros, ones from sign, rotated-out bits)
//   DEF_*        : default operand / shift-amount widths
//   STEP_*       : legal per-cycle step sizes, with a checker function
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // FILL_SIGN means "fill with ones": it is only selected for a negative SRA operand.
    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_SIGN = 2'd1,
        FILL_ROT  = 2'd2
    } fill_mode_e;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SHAMT_W = 5;

    localparam int unsigned STEP_1 = 1;
    localparam int unsigned STEP_2 = 2;
    localparam int unsigned STEP_4 = 4;
    localparam int unsigned STEP_8 = 8;

    function automatic bit step_legal(input int unsigned step);
        return (step == STEP_1) || (step == STEP_2) || (step == STEP_4) || (step == STEP_8);
    endfunction

endpackage

// File: rtl/shr_step.sv
// Combinational single-step right shifter.
//   acc_i  : word to shift
//   k_i    : shift distance for this step, 0..STEP (0 passes acc_i through)
//   mode_i : fill mode for the vacated MSBs
//   res_o  : shifted word
module shr_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned STEP  = STEP_1,
    localparam int unsigned KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [KW-1:0]    k_i,
    input  fill_mode_e       mode_i,
    output logic [WIDTH-1:0] res_o
);

    // Only STEP+1 distinct distances exist, so a small mux of constant shifts
    // is cheaper than a general barrel shifter.
    always_comb begin
        res_o = acc_i;
        for (int unsigned j = 1; j <= STEP; j++) begin
            if (k_i == KW'(j)) begin
                unique case (mode_i)
                    FILL_ROT:  res_o = (acc_i >> j) | (acc_i << (WIDTH - j));
                    FILL_SIGN: res_o = (acc_i >> j) | ~({WIDTH{1'b1}} >> j);
                    default:   res_o = acc_i >> j;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle right shifter (SRL / SRA / SRLV / SRAV), STEP bits per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : request, accepted in IDLE or DONE
//   val_i     : operand
//   shamt_i   : shift amount, 0..WIDTH-1
//   arith_i   : 1 = sign fill, 0 = zero fill
//   rot_i     : 1 = rotate right (only when SHIFT_RIGHT_ROTATE_EN is defined)
//   busy_o    : high while shifting
//   done_o    : one-cycle pulse, result_o valid
//   result_o  : shifted value, held until the next accepted request
// Optional feature macro: SHIFT_RIGHT_ROTATE_EN adds rot_i and the ROTR mode.
module shift_right_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W,
    parameter int unsigned STEP    = STEP_1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   val_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
`ifdef SHIFT_RIGHT_ROTATE_EN
    input  logic               rot_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o
);

    localparam int unsigned KW = $clog2(STEP + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    fill_mode_e         mode_q, mode_d;

    logic               rot_req;
    logic               accept;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_res;

`ifdef SHIFT_RIGHT_ROTATE_EN
    assign rot_req = rot_i;
`else
    assign rot_req = 1'b0;
`endif

    assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));

    // k = min(STEP, cnt)
    always_comb begin
        if (32'(cnt_q) >= STEP) begin
            k = KW'(STEP);
        end else begin
            k = KW'(cnt_q);
        end
    end

    shr_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shr_step (
        .acc_i  (acc_q),
        .k_i    (k),
        .mode_i (mode_q),
        .res_o  (step_res)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    acc_d = val_i;
                    cnt_d = shamt_i;
                    // Rotate overrides arith; a non-negative SRA is just a zero fill.
                    if (rot_req) begin
                        mode_d = FILL_ROT;
                    end else if (arith_i && val_i[WIDTH-1]) begin
                        mode_d = FILL_SIGN;
                    end else begin
                        mode_d = FILL_ZERO;
                    end
                    state_d = (shamt_i == '0) ? DONE : SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = step_res;
                cnt_d = cnt_q - SHAMT_W'(k);
                if (32'(cnt_q) <= STEP) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= FILL_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign busy_o   = (state_q == SHIFT);
    assign done_o   = (state_q == DONE);
    assign result_o = acc_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// Self-checking bench for shift_right_unit: unit 0 uses STEP=1, unit 1 uses STEP=4.
// Stimulus pushes expected result/latency into a per-unit queue; a negedge monitor
// pops and compares on every done_o pulse. Define SHIFT_RIGHT_ROTATE_EN to add ROTR vectors.
module tb_shift_right_unit;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          s;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start [2];
    logic [31:0] val   [2];
    logic [4:0]  shamt [2];
    logic        arith [2];
    logic        rot   [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] res   [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    shift_right_unit #(
        .WIDTH   (32),
        .SHAMT_W (5),
        .STEP    (1)
    ) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start[0]),
        .val_i    (val[0]),
        .shamt_i  (shamt[0]),
        .arith_i  (arith[0]),
`ifdef SHIFT_RIGHT_ROTATE_EN
        .rot_i    (rot[0]),
`endif
        .busy_o   (busy[0]),
        .done_o   (done[0]),
        .result_o (res[0])
    );

    shift_right_unit #(
        .WIDTH   (32),
        .SHAMT_W (5),
        .STEP    (4)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start[1]),
        .val_i    (val[1]),
        .shamt_i  (shamt[1]),
        .arith_i  (arith[1]),
`ifdef SHIFT_RIGHT_ROTATE_EN
        .rot_i    (rot[1]),
`endif
        .busy_o   (busy[1]),
        .done_o   (done[1]),
        .result_o (res[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic mon(input int u);
        exp_t e;
        int   sz;
        sz = (u == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done u%0d: done_o=1 at cycle %0d, required no pulse", u, cyc);
            return;
        end
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check({e.name, " result"}, res[u], e.res);
        check({e.name, " latency"}, 32'(cyc - e.s), 32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                if (done[u]) mon(u);
            end
        end
    end

    // Called at a negedge; returns 1 time unit after the accepting edge.
    task automatic issue(input int u, input logic [31:0] v, input logic [4:0] sh,
                         input logic ar, input logic ro, input logic [31:0] er,
                         input int el, input logic push, input string name);
        exp_t e;
        start[u] = 1'b1;
        val[u]   = v;
        shamt[u] = sh;
        arith[u] = ar;
        rot[u]   = ro;
        if (push) begin
            e.res  = er;
            e.lat  = el;
            e.s    = cyc;
            e.name = name;
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        // Operands must be ignored after acceptance, so scramble them.
        start[u] = 1'b0;
        val[u]   = $urandom;
        shamt[u] = 5'($urandom);
        arith[u] = ~ar;
        rot[u]   = ~ro;
    endtask

    // Returns at the negedge where done_o is seen high.
    task automatic wait_done(input int u);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done[u]) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL timeout u%0d: done_o=0 after 100 cycles, required 1", u);
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0;
            val[u]   = '0;
            shamt[u] = '0;
            arith[u] = 1'b0;
            rot[u]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy[0]), 32'd0);
        check("reset done", 32'(done[0]), 32'd0);
        check("reset result u0", res[0], 32'h0);
        check("reset result u1", res[1], 32'h0);

        // SRL by 4: busy on cycles 1-4, done on cycle 5.
        issue(0, 32'h8000_0000, 5'd4, 1'b0, 1'b0, 32'h0800_0000, 5, 1'b1, "srl4");
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("srl4 busy c%0d", i), 32'(busy[0]), 32'd1);
        end
        wait_done(0);
        check("srl4 busy at done", 32'(busy[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("srl4 result held", res[0], 32'h0800_0000);
        check("srl4 idle done", 32'(done[0]), 32'd0);

        issue(0, 32'h8000_0000, 5'd4, 1'b1, 1'b0, 32'hF800_0000, 5, 1'b1, "sra4");
        wait_done(0);
        issue(0, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF, 32, 1'b1, "sra31neg");
        wait_done(0);
        issue(0, 32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, 32'h0000_0000, 32, 1'b1, "sra31pos");
        wait_done(0);
        issue(0, 32'hDEAD_BEEF, 5'd16, 1'b0, 1'b0, 32'h0000_DEAD, 17, 1'b1, "srl16");
        wait_done(0);
        repeat (2) @(negedge clk);

        // Zero shift goes straight to DONE.
        issue(0, 32'h1234_5678, 5'd0, 1'b1, 1'b0, 32'h1234_5678, 1, 1'b1, "shamt0");
        check("shamt0 busy", 32'(busy[0]), 32'd0);
        wait_done(0);
        check("shamt0 busy at done", 32'(busy[0]), 32'd0);

        // Back-to-back: second request accepted during DONE, done_o stays high.
        issue(0, 32'h0000_00F0, 5'd2, 1'b0, 1'b0, 32'h0000_003C, 3, 1'b1, "b2b_a");
        wait_done(0);
        issue(0, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 32'h0000_00AB, 1, 1'b1, "b2b_b");
        @(negedge clk);
        check("b2b no bubble", 32'(done[0]), 32'd1);

        // Start while busy is ignored.
        issue(0, 32'hFFFF_0000, 5'd8, 1'b0, 1'b0, 32'h00FF_FF00, 9, 1'b1, "collide");
        @(negedge clk);
        @(negedge clk);
        start[0] = 1'b1;
        val[0]   = 32'h0000_0001;
        shamt[0] = 5'd3;
        arith[0] = 1'b0;
        rot[0]   = 1'b0;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0);
        repeat (12) @(negedge clk);

        // Reset mid-shift discards the operation.
        issue(0, 32'hFFFF_FFFF, 5'd10, 1'b1, 1'b0, 32'h0, 0, 1'b0, "abort");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy[0]), 32'd0);
        check("abort done", 32'(done[0]), 32'd0);
        check("abort result", res[0], 32'h0);
        repeat (20) @(negedge clk);
        check("abort still idle", 32'(busy[0]), 32'd0);

        // STEP=4 unit.
        issue(1, 32'h8000_0000, 5'd9, 1'b1, 1'b0, 32'hFFC0_0000, 4, 1'b1, "s4_sra9");
        wait_done(1);
        issue(1, 32'h1234_5678, 5'd8, 1'b0, 1'b0, 32'h0012_3456, 3, 1'b1, "s4_srl8");
        wait_done(1);
        issue(1, 32'hF000_0000, 5'd3, 1'b1, 1'b0, 32'hFE00_0000, 2, 1'b1, "s4_sra3");
        wait_done(1);
        issue(1, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF, 9, 1'b1, "s4_sra31");
        wait_done(1);

`ifdef SHIFT_RIGHT_ROTATE_EN
        issue(0, 32'h0000_0001, 5'd1, 1'b0, 1'b1, 32'h8000_0000, 2, 1'b1, "rot1");
        wait_done(0);
        issue(0, 32'h0000_000F, 5'd4, 1'b0, 1'b1, 32'hF000_0000, 5, 1'b1, "rot4");
        wait_done(0);
        issue(0, 32'h8000_0001, 5'd1, 1'b1, 1'b1, 32'hC000_0000, 2, 1'b1, "rot_over_sra");
        wait_done(0);
        issue(1, 32'h1234_5678, 5'd8, 1'b0, 1'b1, 32'h7812_3456, 3, 1'b1, "s4_rot8");
        wait_done(1);
        issue(1, 32'h0000_000F, 5'd5, 1'b0, 1'b1, 32'h7800_0000, 3, 1'b1, "s4_rot5");
        wait_done(1);
`endif

        repeat (5) @(negedge clk);
        check("queue0 drained", 32'(q0.size()), 32'd0);
        check("queue1 drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
